spi_master_param: RTL



---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_clk_tick.sv | 18 +
 rtl/spi_master_param.sv | 100 ++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and SPI mode constants ({cpol,cpha}) for the SPI master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, FINISH} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: SCLK half-period counter; tick pulses on the last clk of every half-period while en is high
// ports: clk, rst (async, active-high), en (count enable, counter clears when low), tick (one-cycle pulse)
module spi_clk_tick #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(HALF_PERIOD - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= (en && !tick) ? cnt + 1'b1 : '0;
  end
endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master, all four modes, MSB/LSB-first, NUM_CS chip selects
// ports: clk, rst (async, active-high); start/cs_sel/cpol/cpha/lsb_first/tx_data request a transfer;
//        rx_data/busy/done/err report it; SCLK/MOSI/MISO/cs_n are the SPI bus (cs_n active-low)
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int HALF_PERIOD = 2,
  parameter int NUM_CS      = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [(NUM_CS > 1 ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
  input  logic                                      cpol,
  input  logic                                      cpha,
  input  logic                                      lsb_first,
  input  logic [DATA_W-1:0]                         tx_data,
  output logic [DATA_W-1:0]                         rx_data,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err,
  output logic                                      SCLK,
  output logic                                      MOSI,
  input  logic                                      MISO,
  output logic [NUM_CS-1:0]                         cs_n
);
  localparam int SEL_W = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W - 1);
  state_t state, nxt;
  logic tick, en, accept, cap, drv, edge_tick, cpol_l, cpha_l, lsb_l;
  logic [SEL_W-1:0] sel_l;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [EW-1:0] edge_cnt;
  assign en = state inside {SETUP, SHIFT, HOLD};
  assign accept = state == IDLE && start && 32'(cs_sel) < NUM_CS;
  assign edge_tick = tick && state inside {SETUP, SHIFT};
  // even edges are leading: capture there when cpha=0, on odd (trailing) edges when cpha=1
  assign cap = edge_cnt[0] == cpha_l;
  // drive on the non-capture edge; with cpha=0 the final trailing edge has no next bit
  assign drv = !cap && edge_cnt != LAST;
  spi_clk_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (.clk(clk), .rst(rst), .en(en), .tick(tick));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    busy = state != IDLE;
    done = state == FINISH;
    cs_n = en ? ~(NUM_CS'(1) << sel_l) : '1;
    unique case (state)
      IDLE:    nxt = accept ? SETUP : IDLE;
      SETUP:   nxt = tick ? SHIFT : SETUP;
      SHIFT:   nxt = (tick && edge_cnt == LAST) ? HOLD : SHIFT;
      HOLD:    nxt = tick ? FINISH : HOLD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SCLK <= 1'b0;
      MOSI <= 1'b0;
      err <= 1'b0;
      rx_data <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      edge_cnt <= '0;
      sel_l <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      lsb_l <= 1'b0;
    end else begin
      err <= state == IDLE && start && !accept;
      if (state == IDLE) SCLK <= cpol;
      if (state == HOLD) SCLK <= cpol_l;
      if (accept) begin
        sel_l <= cs_sel;
        cpol_l <= cpol;
        cpha_l <= cpha;
        lsb_l <= lsb_first;
        edge_cnt <= '0;
        // cpha=0 presents the first bit before any edge, so it leaves the shifter already consumed
        tx_sr <= cpha ? tx_data : (lsb_first ? tx_data >> 1 : tx_data << 1);
        if (!cpha) MOSI <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
      end
      if (edge_tick) begin
        SCLK <= ~SCLK;
        edge_cnt <= edge_cnt + 1'b1;
        if (cap) rx_sr <= lsb_l ? {MISO, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], MISO};
        if (drv) begin
          MOSI <= lsb_l ? tx_sr[0] : tx_sr[DATA_W-1];
          tx_sr <= lsb_l ? tx_sr >> 1 : tx_sr << 1;
        end
      end
      if (tick && state == HOLD) rx_data <= rx_sr;
    end
  end
endmodule
